// File: rtl/traffic_lamp_monitor.sv
// -----------------------------------------------------------------------------
// traffic_lamp_monitor
//   Receive-side checker for the one-hot lamp bus of a traffic-light controller
//   (RED=3'b100, GREEN=3'b010, YELLOW=3'b001). Each clock it samples the bus and
//   checks code legality, phase order RED->GREEN->YELLOW->RED and per-phase
//   dwell time. The first violation latches a sticky fault with a cause code.
//   Completed light cycles (YELLOW->RED transitions) are counted.
//
// Ports
//   clk         in   1      clock, all state updates on posedge
//   rst_n       in   1      asynchronous active-low reset
//   lamp        in   3      lamp bus under test
//   clear       in   1      one-cycle pulse: clear fault, return to SYNC
//   fault       out  1      sticky fault flag
//   fault_code  out  3      000 none, 001 illegal code, 010 illegal order,
//                           011 dwell short, 100 dwell long
//   phase       out  2      tracked phase: 00 RED, 01 GREEN, 10 YELLOW
//   in_sync     out  1      monitor locked to a legal phase
//   cycle_cnt   out  CNT_W  completed YELLOW->RED transitions (wraps)
// -----------------------------------------------------------------------------
module traffic_lamp_monitor #(
    parameter int MIN_DWELL = 1,
    parameter int MAX_DWELL = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       lamp,
    input  logic             clear,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       phase,
    output logic             in_sync,
    output logic [CNT_W-1:0] cycle_cnt
);

    // Dwell counter only needs to reach MAX_DWELL: the sample after that faults.
    localparam int DW_W = $clog2(MAX_DWELL + 1);
    localparam logic [DW_W-1:0] MIN_DW = DW_W'(MIN_DWELL);
    localparam logic [DW_W-1:0] MAX_DW = DW_W'(MAX_DWELL);

    localparam logic [1:0] PH_RED    = 2'b00;
    localparam logic [1:0] PH_GREEN  = 2'b01;
    localparam logic [1:0] PH_YELLOW = 2'b10;

    localparam logic [2:0] CODE_NONE    = 3'b000;
    localparam logic [2:0] CODE_ILLEGAL = 3'b001;
    localparam logic [2:0] CODE_ORDER   = 3'b010;
    localparam logic [2:0] CODE_SHORT   = 3'b011;
    localparam logic [2:0] CODE_LONG    = 3'b100;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'b00,
        ST_TRACK = 2'b01,
        ST_FAULT = 2'b10
    } state_t;

    // Only the three one-hot lamp codes are legal.
    function automatic logic f_is_legal(input logic [2:0] code);
        logic ok;
        case (code)
            3'b100, 3'b010, 3'b001: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Map a legal lamp code onto the phase encoding.
    function automatic logic [1:0] f_code2phase(input logic [2:0] code);
        logic [1:0] ph;
        case (code)
            3'b100:  ph = PH_RED;
            3'b010:  ph = PH_GREEN;
            3'b001:  ph = PH_YELLOW;
            default: ph = PH_RED;
        endcase
        return ph;
    endfunction

    // Successor phase in the RED->GREEN->YELLOW->RED ring.
    function automatic logic [1:0] f_next_phase(input logic [1:0] ph);
        logic [1:0] nx;
        case (ph)
            PH_RED:    nx = PH_GREEN;
            PH_GREEN:  nx = PH_YELLOW;
            PH_YELLOW: nx = PH_RED;
            default:   nx = PH_RED;
        endcase
        return nx;
    endfunction

    state_t             r_state;
    logic [1:0]         r_phase;
    logic [DW_W-1:0]    r_dwell;
    logic               r_first;
    logic               r_fault;
    logic [2:0]         r_fault_code;
    logic               r_in_sync;
    logic [CNT_W-1:0]   r_cycle_cnt;

    logic               w_legal;
    logic [1:0]         w_lamp_phase;
    logic [1:0]         w_next_phase;
    logic               w_is_same;
    logic               w_is_next;
    logic [2:0]         w_cause;

    assign w_legal      = f_is_legal(lamp);
    assign w_lamp_phase = f_code2phase(lamp);
    assign w_next_phase = f_next_phase(r_phase);
    assign w_is_same    = w_legal && (w_lamp_phase == r_phase);
    assign w_is_next    = w_legal && (w_lamp_phase == w_next_phase);

    // Violation cause for the current sample while tracking, highest priority first.
    always_comb begin
        w_cause = CODE_NONE;
        if (!w_legal) begin
            w_cause = CODE_ILLEGAL;
        end else if (!w_is_same && !w_is_next) begin
            w_cause = CODE_ORDER;
        end else if (w_is_next && (r_dwell < MIN_DW) && !r_first) begin
            // r_first spares the partially observed phase seen right after lock.
            w_cause = CODE_SHORT;
        end else if (w_is_same && (r_dwell == MAX_DW)) begin
            w_cause = CODE_LONG;
        end else begin
            w_cause = CODE_NONE;
        end
    end

    // Monitor FSM with registered outputs; clear overrides anything detected this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_SYNC;
            r_phase      <= PH_RED;
            r_dwell      <= '0;
            r_first      <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= CODE_NONE;
            r_in_sync    <= 1'b0;
            r_cycle_cnt  <= '0;
        end else if (clear) begin
            // cycle_cnt deliberately survives a clear.
            r_state      <= ST_SYNC;
            r_phase      <= PH_RED;
            r_dwell      <= '0;
            r_first      <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= CODE_NONE;
            r_in_sync    <= 1'b0;
        end else begin
            case (r_state)
                ST_SYNC: begin
                    if (w_legal) begin
                        r_state   <= ST_TRACK;
                        r_phase   <= w_lamp_phase;
                        r_dwell   <= DW_W'(1);
                        r_first   <= 1'b1;
                        r_in_sync <= 1'b1;
                    end else begin
                        r_state   <= ST_SYNC;
                    end
                end
                ST_TRACK: begin
                    if (w_cause != CODE_NONE) begin
                        r_state      <= ST_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_cause;
                        r_in_sync    <= 1'b0;
                    end else if (w_is_same) begin
                        r_dwell <= r_dwell + DW_W'(1);
                    end else begin
                        r_phase <= w_next_phase;
                        r_dwell <= DW_W'(1);
                        r_first <= 1'b0;
                        if (r_phase == PH_YELLOW) begin
                            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
                        end else begin
                            r_cycle_cnt <= r_cycle_cnt;
                        end
                    end
                end
                ST_FAULT: begin
                    // Sticky: only clear or reset leave this state.
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state   <= ST_SYNC;
                    r_in_sync <= 1'b0;
                end
            endcase
        end
    end

    assign fault      = r_fault;
    assign fault_code = r_fault_code;
    assign phase      = r_phase;
    assign in_sync    = r_in_sync;
    assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_lamp_monitor
//   Drives three monitor instances (defaults, MIN_DWELL=2, CNT_W=2) with the
//   same lamp/clear stream and compares every output against a reference model
//   built directly from the phase-ring and dwell rules, plus directed scenarios
//   with fixed expected values.
// -----------------------------------------------------------------------------
module tb_traffic_lamp_monitor;

    logic       clk;
    logic       rst_n;
    logic [2:0] lamp;
    logic       clear;

    logic       fault_a, fault_b, fault_c;
    logic [2:0] code_a, code_b, code_c;
    logic [1:0] phase_a, phase_b, phase_c;
    logic       sync_a, sync_b, sync_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per instance: st 0=SYNC 1=TRACK 2=FAULT
    int m_min  [3] = '{1, 2, 1};
    int m_max  [3] = '{4, 4, 4};
    int m_cntw [3] = '{8, 8, 2};
    int m_st   [3];
    int m_ph   [3];
    int m_dw   [3];
    int m_first[3];
    int m_cnt  [3];
    int m_fault[3];
    int m_code [3];

    traffic_lamp_monitor u_a (
        .clk(clk), .rst_n(rst_n), .lamp(lamp), .clear(clear),
        .fault(fault_a), .fault_code(code_a), .phase(phase_a),
        .in_sync(sync_a), .cycle_cnt(cnt_a)
    );

    traffic_lamp_monitor #(.MIN_DWELL(2)) u_b (
        .clk(clk), .rst_n(rst_n), .lamp(lamp), .clear(clear),
        .fault(fault_b), .fault_code(code_b), .phase(phase_b),
        .in_sync(sync_b), .cycle_cnt(cnt_b)
    );

    traffic_lamp_monitor #(.CNT_W(2)) u_c (
        .clk(clk), .rst_n(rst_n), .lamp(lamp), .clear(clear),
        .fault(fault_c), .fault_code(code_c), .phase(phase_c),
        .in_sync(sync_c), .cycle_cnt(cnt_c)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Position of a lamp code in the ring, -1 if not a one-hot code.
    function automatic int lamp_idx(input logic [2:0] l);
        if (l == 3'b100) return 0;
        if (l == 3'b010) return 1;
        if (l == 3'b001) return 2;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_ph[i] = 0; m_dw[i] = 0; m_first[i] = 0;
            m_cnt[i] = 0; m_fault[i] = 0; m_code[i] = 0;
        end
    endtask

    task automatic model_step(input logic [2:0] l, input logic c);
        int k;
        int nx;
        k = lamp_idx(l);
        for (int i = 0; i < 3; i++) begin
            nx = (m_ph[i] + 1) % 3;
            if (c) begin
                m_st[i] = 0; m_fault[i] = 0; m_code[i] = 0; m_ph[i] = 0; m_dw[i] = 0;
            end else if (m_st[i] == 0) begin
                if (k >= 0) begin
                    m_st[i] = 1; m_ph[i] = k; m_dw[i] = 1; m_first[i] = 1;
                end
            end else if (m_st[i] == 1) begin
                if (k < 0) begin
                    m_st[i] = 2; m_fault[i] = 1; m_code[i] = 1;
                end else if (k != m_ph[i] && k != nx) begin
                    m_st[i] = 2; m_fault[i] = 1; m_code[i] = 2;
                end else if (k == nx && m_dw[i] < m_min[i] && m_first[i] == 0) begin
                    m_st[i] = 2; m_fault[i] = 1; m_code[i] = 3;
                end else if (k == m_ph[i] && m_dw[i] == m_max[i]) begin
                    m_st[i] = 2; m_fault[i] = 1; m_code[i] = 4;
                end else if (k == m_ph[i]) begin
                    m_dw[i]++;
                end else begin
                    if (m_ph[i] == 2) m_cnt[i] = (m_cnt[i] + 1) % (1 << m_cntw[i]);
                    m_ph[i] = k; m_dw[i] = 1; m_first[i] = 0;
                end
            end
        end
    endtask

    task automatic check_one(input string tag, input int i, input logic f, input logic [2:0] cd,
                             input logic [1:0] ph, input logic s, input logic [7:0] cn);
        chk($sformatf("%s_u%0d_fault", tag, i), 32'(f), 32'(m_fault[i]));
        chk($sformatf("%s_u%0d_code", tag, i), 32'(cd), 32'(m_code[i]));
        chk($sformatf("%s_u%0d_phase", tag, i), 32'(ph), 32'((m_st[i] == 0) ? 0 : m_ph[i]));
        chk($sformatf("%s_u%0d_sync", tag, i), 32'(s), 32'(m_st[i] == 1));
        chk($sformatf("%s_u%0d_cnt", tag, i), 32'(cn), 32'(m_cnt[i]));
    endtask

    task automatic check_all(input string tag);
        check_one(tag, 0, fault_a, code_a, phase_a, sync_a, cnt_a);
        check_one(tag, 1, fault_b, code_b, phase_b, sync_b, cnt_b);
        check_one(tag, 2, fault_c, code_c, phase_c, sync_c, {6'd0, cnt_c});
    endtask

    // One sampled clock: drive, step the model at the edge, compare just after.
    task automatic cyc(input string tag, input logic [2:0] l, input logic c);
        lamp  = l;
        clear = c;
        @(posedge clk);
        model_step(l, c);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    logic [2:0] rl;
    logic       rc;
    int         cur;
    int         rem;

    initial begin
        rst_n = 1'b0;
        lamp  = 3'b000;
        clear = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Nominal one-sample-per-phase running, ends on RED to close the 3rd cycle
        for (int r = 0; r < 3; r++) begin
            cyc("t1", 3'b100, 1'b0);
            if (r == 0) chk("t1_sync_first", 32'(sync_a), 32'd1);
            cyc("t1", 3'b010, 1'b0);
            cyc("t1", 3'b001, 1'b0);
        end
        cyc("t1", 3'b100, 1'b0);
        chk("t1_cnt", 32'(cnt_a), 32'd3);
        chk("t1_nofault", 32'(fault_a), 32'd0);

        // Illegal code while on GREEN, then sticky under legal lamps
        cyc("t2", 3'b010, 1'b0);
        cyc("t2", 3'b011, 1'b0);
        chk("t2_code", 32'(code_a), 32'd1);
        cyc("t2", 3'b001, 1'b0);
        cyc("t2", 3'b100, 1'b0);
        chk("t2_sticky", {31'd0, fault_a}, 32'd1);
        chk("t2_code_hold", 32'(code_a), 32'd1);

        // RED straight to YELLOW
        cyc("t3", 3'b000, 1'b1);
        cyc("t3", 3'b100, 1'b0);
        cyc("t3", 3'b001, 1'b0);
        chk("t3_code", 32'(code_a), 32'd2);
        chk("t3_cnt", 32'(cnt_a), 32'd3);

        // Short GREEN after a full RED on the MIN_DWELL=2 instance
        cyc("t4b", 3'b000, 1'b1);
        cyc("t4b", 3'b100, 1'b0);
        cyc("t4b", 3'b100, 1'b0);
        cyc("t4b", 3'b010, 1'b0);
        cyc("t4b", 3'b001, 1'b0);
        chk("t4b_code", 32'(code_b), 32'd3);

        // GREEN held one sample too long
        cyc("t4a", 3'b000, 1'b1);
        cyc("t4a", 3'b100, 1'b0);
        for (int g = 0; g < 5; g++) begin
            cyc("t4a", 3'b010, 1'b0);
            if (g == 3) chk("t4a_ok_at_max", 32'(fault_a), 32'd0);
        end
        chk("t4a_code", 32'(code_a), 32'd4);

        // Clear out of FAULT, resync, and clear beating a same-edge fault
        cyc("t5", 3'b000, 1'b1);
        chk("t5_code", 32'(code_a), 32'd0);
        chk("t5_sync", 32'(sync_a), 32'd0);
        cyc("t5", 3'b010, 1'b0);
        chk("t5_phase", 32'(phase_a), 32'd1);
        cyc("t5", 3'b011, 1'b1);
        chk("t5_clear_wins", 32'(fault_a), 32'd0);

        // Randomized legal-ish traffic with occasional glitches, jumps and clears
        cur = 0;
        rem = 0;
        for (int n = 0; n < 1500; n++) begin
            rc = ($urandom_range(0, 99) < 2) || (m_st[0] == 2 && $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) < 4) begin
                rl = 3'($urandom_range(0, 7));
            end else begin
                if (rem == 0) begin
                    if ($urandom_range(0, 99) < 90) cur = (cur + 1) % 3;
                    else cur = $urandom_range(0, 2);
                    rem = $urandom_range(1, 5);
                end
                rem--;
                rl = 3'b100 >> cur;
            end
            cyc("rand", rl, rc);
        end

        // Counter wrap on the CNT_W=2 instance, then async reset mid-GREEN
        #2;
        do_reset();
        for (int r = 0; r < 5; r++) begin
            cyc("t6", 3'b100, 1'b0);
            cyc("t6", 3'b010, 1'b0);
            cyc("t6", 3'b001, 1'b0);
        end
        cyc("t6", 3'b100, 1'b0);
        chk("t6_wrap", 32'(cnt_c), 32'd1);
        chk("t6_nowrap", 32'(cnt_a), 32'd5);
        cyc("t6", 3'b010, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("t6_async");
        chk("t6_async_sync", 32'(sync_a), 32'd0);
        chk("t6_async_cnt", 32'(cnt_a), 32'd0);
        #3;
        rst_n = 1'b1;
        cyc("t6_post", 3'b001, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
